// File: rtl/crc8_pkg.sv
// Shared definitions for the CRC-8 (x^8+x^2+x+1, init 0xFF, MSB-first) generator/checker pair.
package crc8_pkg;

   localparam logic [7:0] CRC8_INIT = 8'hFF;
   localparam logic [7:0] CRC8_POLY = 8'h07;

   typedef enum logic [1:0] {
      ST_OK    = 2'd0,
      ST_CRC   = 2'd1,
      ST_LONG  = 2'd2,
      ST_ABORT = 2'd3
   } status_t;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PAYLOAD = 2'd1,
      S_RESULT  = 2'd2
   } state_t;

   // Byte-parallel update: xor the byte into the register, then eight MSB-first shifts.
   function automatic logic [7:0] crc8_byte(input logic [7:0] lfsr, input logic [7:0] data);
      logic [7:0] x;
      x = lfsr ^ data;
      for (int i = 0; i < 8; i++) begin
         x = x[7] ? ((x << 1) ^ CRC8_POLY) : (x << 1);
      end
      return x;
   endfunction

endpackage

// File: rtl/crc8_frame_checker_if.sv
// Byte-stream input and result handshake between a frame source/consumer and the CRC-8 checker.
interface crc8_frame_checker_if #(
   parameter int LEN_W = 9
);
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_data;
   logic             in_sof;
   logic             in_eof;
   logic             res_valid;
   logic             res_ready;
   logic             res_ok;
   logic [1:0]       res_status;
   logic [LEN_W-1:0] res_len;
   logic [7:0]       res_crc;

   modport master (
      output in_valid, in_data, in_sof, in_eof, res_ready,
      input  in_ready, res_valid, res_ok, res_status, res_len, res_crc
   );

   modport slave (
      input  in_valid, in_data, in_sof, in_eof, res_ready,
      output in_ready, res_valid, res_ok, res_status, res_len, res_crc
   );
endinterface

// File: rtl/crc8_d8_next.sv
// Combinational CRC-8 next-state for one data byte; shared by the generator and checker ends.
module crc8_d8_next
   import crc8_pkg::*;
(
   input  logic [7:0] lfsr_in,
   input  logic [7:0] data,
   output logic [7:0] lfsr_out
);

   assign lfsr_out = crc8_byte(lfsr_in, data);

endmodule

// File: rtl/crc8_frame_checker.sv
// Receive-side CRC-8 frame checker: recomputes CRC over the payload, compares with the trailing
// byte and reports one registered result per frame, plus frame/error counters.
//
// state     | meaning
// S_IDLE    | waiting for sof; non-sof beats are accepted and dropped
// S_PAYLOAD | accumulating payload bytes into the lfsr until eof or an aborting sof
// S_RESULT  | result held on res_* until res_ready; input stalled
module crc8_frame_checker
   import crc8_pkg::*;
#(
   parameter int MAX_LEN = 256,
   parameter int LEN_W   = 9,
   parameter int CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   crc8_frame_checker_if.slave   bus,
   output logic [CNT_W-1:0]      frame_cnt,
   output logic [CNT_W-1:0]      err_cnt
);

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);

   state_t           state;
   logic [7:0]       lfsr;
   logic [7:0]       lfsr_nxt;
   logic [LEN_W-1:0] len;
   logic             issue;
   status_t          issue_status;
   status_t          eof_status;

   // In IDLE the lfsr always holds CRC8_INIT, so one instance covers both the first and later bytes.
   crc8_d8_next u_next (
      .lfsr_in  (lfsr),
      .data     (bus.in_data),
      .lfsr_out (lfsr_nxt)
   );

   assign bus.in_ready = (state == S_IDLE) |
                         ((state == S_PAYLOAD) & ~(bus.in_valid & bus.in_sof));

   always_comb begin
      eof_status = ST_OK;
      if (len > LEN_MAX)
         eof_status = ST_LONG;
      else if (bus.in_data != lfsr)
         eof_status = ST_CRC;
   end

   always_comb begin
      issue        = 1'b0;
      issue_status = ST_OK;
      case (state)
         S_IDLE: begin
            if (bus.in_valid && bus.in_sof && bus.in_eof) begin
               issue        = 1'b1;
               issue_status = eof_status;
            end
         end
         S_PAYLOAD: begin
            if (bus.in_valid && bus.in_sof) begin
               issue        = 1'b1;
               issue_status = ST_ABORT;
            end else if (bus.in_valid && bus.in_eof) begin
               issue        = 1'b1;
               issue_status = eof_status;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         lfsr           <= CRC8_INIT;
         len            <= '0;
         bus.res_valid  <= 1'b0;
         bus.res_ok     <= 1'b0;
         bus.res_status <= 2'd0;
         bus.res_len    <= '0;
         bus.res_crc    <= 8'h00;
         frame_cnt      <= '0;
         err_cnt        <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid && bus.in_sof && !bus.in_eof) begin
                  lfsr  <= lfsr_nxt;
                  len   <= LEN_W'(1);
                  state <= S_PAYLOAD;
               end
            end
            S_PAYLOAD: begin
               if (bus.in_valid && !bus.in_sof && !bus.in_eof) begin
                  lfsr <= lfsr_nxt;
                  if (len != LEN_SAT)
                     len <= len + LEN_W'(1);
               end
            end
            S_RESULT: begin
               if (bus.res_ready) begin
                  bus.res_valid <= 1'b0;
                  lfsr          <= CRC8_INIT;
                  len           <= '0;
                  state         <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase

         if (issue) begin
            state          <= S_RESULT;
            bus.res_valid  <= 1'b1;
            bus.res_ok     <= (issue_status == ST_OK);
            bus.res_status <= issue_status;
            bus.res_len    <= len;
            bus.res_crc    <= lfsr;
            frame_cnt      <= frame_cnt + CNT_W'(1);
            if (issue_status != ST_OK)
               err_cnt <= err_cnt + CNT_W'(1);
         end
      end
   end

endmodule
